// File: rtl/boid_draw_reader.sv
// boid_draw_reader
//   Walks every boid once per start pulse, reads its fixed-point position from
//   boid memory, converts it to a VGA framebuffer address, erases the pixel
//   drawn for that boid on the previous pass and draws the new one.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   start                 one-cycle pulse, begins a draw pass (IDLE only)
//   busy, done            pass in progress / one-cycle completion pulse
//   rd_en, rd_addr        boid-memory read strobe and boid index
//   x_rd, y_rd            boid x (Q11.16) and y (Q10.16), signed
//   pix_wr_en, pix_addr,  framebuffer write port (valid/ready); the request
//   pix_data, pix_ready   is held stable until pix_wr_en && pix_ready
module boid_draw_reader #(
    parameter int         N_BOIDS     = 2,
    parameter int         MEM_LAT     = 1,
    parameter int         SCREEN_W    = 640,
    parameter int         SCREEN_H    = 480,
    parameter logic [7:0] DRAW_COLOR  = 8'hFF,
    parameter logic [7:0] ERASE_COLOR = 8'h00
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [$clog2(N_BOIDS):0] rd_addr,
    input  logic [27:0]              x_rd,
    input  logic [26:0]              y_rd,
    output logic                     pix_wr_en,
    output logic [18:0]              pix_addr,
    output logic [7:0]               pix_data,
    input  logic                     pix_ready
);

    localparam int IW = $clog2(N_BOIDS) + 1;
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    // Per-boid tables are sized to the full index range so i_q indexes them
    // without width adaptation; entries past N_BOIDS are never touched.
    localparam int NTAB = 2 ** IW;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_CALC, S_ERASE, S_DRAW, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     i_q;
    logic [CW-1:0]     wait_q;
    logic signed [11:0] px_q;
    logic signed [10:0] py_q;
    logic              new_valid_q;
    logic [18:0]       new_addr_q;
    logic [18:0]       old_addr_q [NTAB];
    logic [NTAB-1:0]   old_valid_q;

    logic              last_wait, last_boid, calc_valid, boid_end, end_valid;
    logic [18:0]       calc_addr;
    logic signed [31:0] px_i, py_i;

    // Fractional position bits never influence the pixel address.
    logic unused_frac;
    assign unused_frac = ^{x_rd[15:0], y_rd[15:0]};

    assign last_wait = (wait_q == CW'(MEM_LAT - 1));
    assign last_boid = (i_q == IW'(N_BOIDS - 1));

    // Pixel coordinates are the integer part of the captured positions.
    always_comb begin
        px_i       = 32'(px_q);
        py_i       = 32'(py_q);
        calc_valid = (px_i >= 0) && (px_i < SCREEN_W) &&
                     (py_i >= 0) && (py_i < SCREEN_H);
        calc_addr  = 19'(py_i * SCREEN_W + px_i);
    end

    // A boid is finished whenever the FSM leaves its CALC/ERASE/DRAW group.
    assign boid_end  = (state_q == S_CALC || state_q == S_ERASE || state_q == S_DRAW) &&
                       (state_d == S_READ || state_d == S_DONE);
    assign end_valid = (state_q == S_CALC) ? calc_valid : new_valid_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_READ;
            S_READ:  state_d = S_WAIT;
            S_WAIT:  if (last_wait) state_d = S_CALC;
            S_CALC: begin
                if (old_valid_q[i_q])  state_d = S_ERASE;
                else if (calc_valid)   state_d = S_DRAW;
                else                   state_d = last_boid ? S_DONE : S_READ;
            end
            S_ERASE: if (pix_ready) begin
                if (new_valid_q) state_d = S_DRAW;
                else             state_d = last_boid ? S_DONE : S_READ;
            end
            S_DRAW:  if (pix_ready) state_d = last_boid ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_q         <= '0;
            wait_q      <= '0;
            px_q        <= '0;
            py_q        <= '0;
            new_valid_q <= 1'b0;
            new_addr_q  <= '0;
            old_valid_q <= '0;
            for (int k = 0; k < NTAB; k++) old_addr_q[k] <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) i_q <= '0;
                S_READ: wait_q <= '0;
                S_WAIT: begin
                    wait_q <= wait_q + CW'(1);
                    if (last_wait) begin
                        px_q <= x_rd[27:16];
                        py_q <= y_rd[26:16];
                    end
                end
                S_CALC: begin
                    new_valid_q <= calc_valid;
                    new_addr_q  <= calc_addr;
                end
                default: ;
            endcase
            if (state_q == S_DRAW && pix_ready) old_addr_q[i_q] <= new_addr_q;
            if (boid_end) begin
                old_valid_q[i_q] <= end_valid;
                if (state_d == S_READ) i_q <= i_q + IW'(1);
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        rd_en     = 1'b0;
        rd_addr   = '0;
        pix_wr_en = 1'b0;
        pix_addr  = '0;
        pix_data  = '0;
        case (state_q)
            S_READ: begin
                rd_en   = 1'b1;
                rd_addr = i_q;
            end
            S_ERASE: begin
                pix_wr_en = 1'b1;
                pix_addr  = old_addr_q[i_q];
                pix_data  = ERASE_COLOR;
            end
            S_DRAW: begin
                pix_wr_en = 1'b1;
                pix_addr  = new_addr_q;
                pix_data  = DRAW_COLOR;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/boid_draw_reader.md
Name: boid_draw_reader

Overview:
- Read-side counterpart to the accelerator control/datapath that writes boid state (x, y, vx, vy) into boid memory.
- On each frame-update start, walks all boids, reads each boid's fixed-point position and converts it to a VGA pixel address.
- For each boid, erases the pixel drawn for it on the previous frame, then draws the new pixel into the M10k framebuffer through a valid/ready write port.

Parameters:
- N_BOIDS, 2, number of boids in boid memory.
- MEM_LAT, 1, boid-memory read latency in cycles (>=1).
- SCREEN_W, 640, framebuffer width in pixels.
- SCREEN_H, 480, framebuffer height in pixels.
- DRAW_COLOR, 8'hFF, pixel value written for a boid.
- ERASE_COLOR, 8'h00, pixel value written when erasing.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: boid memory is consistent; begin a draw pass.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse when the pass completes.
- rd_en  out  1  boid-memory read strobe.
- rd_addr  out  $clog2(N_BOIDS)+1  boid index (same width as which_boid).
- x_rd  in  28  boid x, signed, 16 fractional bits.
- y_rd  in  27  boid y, signed, 16 fractional bits.
- pix_wr_en  out  1  framebuffer write valid.
- pix_addr  out  19  framebuffer address, py*SCREEN_W+px.
- pix_data  out  8  pixel value.
- pix_ready  in  1  framebuffer accepts a write.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs are 0; state is IDLE.
  - Per-boid old-address registers are cleared and old_valid[i] = 0, so the first pass after reset does no erases.
  - Reset asserted mid-pass aborts the pass immediately; no done pulse is produced.
- States: IDLE, READ, WAIT, CALC, ERASE, DRAW, DONE.
- IDLE: start=1 moves to READ with i=0. start is ignored in every other state.
- READ (1 cycle): rd_en=1, rd_addr=i.
- WAIT (MEM_LAT cycles): rd_en=0. x_rd/y_rd are valid in cycle t+MEM_LAT, where t is the READ cycle, and are captured at the end of the last WAIT cycle.
- CALC (1 cycle), all results registered:
  - px = x >>> 16 (12-bit signed).
  - py = y >>> 16 (11-bit signed).
  - new_valid = (0 <= px < SCREEN_W) && (0 <= py < SCREEN_H).
  - new_addr = py*SCREEN_W + px, truncated to 19 bits.
- ERASE: entered only if old_valid[i].
  - Drives pix_wr_en=1, pix_addr=old_addr[i], pix_data=ERASE_COLOR.
  - Write completes on the edge where pix_wr_en && pix_ready.
- DRAW: entered only if new_valid.
  - Drives DRAW_COLOR at new_addr.
  - On completion, old_addr[i] is set to new_addr.
- Stall rule: while pix_ready=0, pix_wr_en, pix_addr and pix_data stay stable. pix_wr_en never drops before acceptance.
- Write order: erase-then-draw always, even when old_addr[i]==new_addr; the final pixel is DRAW_COLOR.
- Off-screen boid: if new_valid=0, the DRAW write is skipped.
- old_valid update: old_valid[i] is set to new_valid at the end of the boid's processing, whether or not writes occurred.
- Transitions after a boid:
  - After CALC with no writes needed, or after the last write: if i==N_BOIDS-1, go to DONE; else i++ and go to READ.
  - ERASE goes to DRAW, or skips it when new_valid=0.
- DONE (1 cycle): done=1, busy=1, then IDLE.
- Latency with pix_ready held high: each boid costs 1 + MEM_LAT + 1 + (#writes) cycles, plus 1 DONE cycle.
  - N=2, MEM_LAT=1, first pass, both on-screen: done is asserted 9 cycles after the start edge.
- Boids are processed in ascending index order. A later boid's erase may clear an earlier boid's pixel; this is accepted behaviour.

Test Plan:
- Reset, then N=2, MEM_LAT=1, boid0 x=0x00A0000, y=0x0140000, boid1 x=0x0000000, y=0x0000000, start -> rd_addr sequence 0,1.
  - Exactly two writes: (12810, FF) then (0, FF).
  - done 9 cycles after start; busy high for cycles 1-9.
- Second pass with boid0 moved to x=0x00B0000 (11, 20) -> writes in order (12810, 00), (12811, FF), (0, 00), (0, FF).
- boid0 x=0xFFF0000 (px=-1) -> no boid0 write that pass.
  - Next pass with boid0 back at (10, 20) -> only a draw at 12810, no erase.
- Boundary: px=639, py=479 -> write at 307199. px=640 -> no write.
- pix_ready held low 5 cycles during the first draw -> pix_wr_en/pix_addr/pix_data constant across those cycles; exactly one write counted; done delayed by 5 cycles.
- start pulsed again mid-pass -> ignored, one done only.
  - reset asserted during WAIT -> outputs 0 in the same cycle, no done.
  - Next pass does no erases.
